// File: rtl/his_pkg.sv
// Shared types and sizing helpers for the histogram builder.
package his_pkg;
  localparam int DEF_BIN_W = 8;
  localparam int DEF_PIX_W = 2;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_BUILD, S_DRAIN, S_SCAN, S_DONE
  } his_state_e;

  function automatic int ram_aw(input int pix_w, input int bin_w);
    return pix_w + bin_w;
  endfunction

  function automatic int unsigned cnt_max(input int cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction
endpackage

// File: rtl/his_rmw_pipe.sv
// Read-modify-write pipeline: issue read, wait for RAM data, write back a
// saturating increment; also owns the RAM port registers for clear and scan.
module his_rmw_pipe
  import his_pkg::*;
#(
  parameter int RAM_AW = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              acc,
  input  logic [RAM_AW-1:0] acc_addr,
  input  logic              rd_req,
  input  logic [RAM_AW-1:0] rd_addr,
  input  logic              clr_req,
  input  logic [RAM_AW-1:0] clr_addr,
  input  logic              sat_clr,
  input  logic [CNT_W-1:0]  rdata,
  output logic              ren,
  output logic [RAM_AW-1:0] raddr,
  output logic              wen,
  output logic [RAM_AW-1:0] waddr,
  output logic [CNT_W-1:0]  wdata,
  output logic              sat_flag,
  output logic              empty
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [1:0]        vld_pipe;
  logic [RAM_AW-1:0] s2_addr;
  logic              w1_vld;
  logic [RAM_AW-1:0] w1_addr;
  logic [CNT_W-1:0]  w1_data;
  logic [CNT_W-1:0]  base, inc;
  logic              sat_hit;

  assign empty = ~|vld_pipe;

  // The last two writes have not reached rdata yet; the youngest one wins.
  always_comb begin
    base = rdata;
    if (wen && waddr == s2_addr)         base = wdata;
    else if (w1_vld && w1_addr == s2_addr) base = w1_data;
    sat_hit = (base == CNT_MAX);
    inc     = sat_hit ? base : base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      vld_pipe <= '0;
      ren      <= 1'b0;
      raddr    <= '0;
      s2_addr  <= '0;
      wen      <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      w1_vld   <= 1'b0;
      w1_addr  <= '0;
      w1_data  <= '0;
      sat_flag <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], acc};
      ren      <= acc | rd_req;
      raddr    <= acc ? acc_addr : rd_addr;
      s2_addr  <= raddr;
      wen      <= clr_req | vld_pipe[1];
      waddr    <= clr_req ? clr_addr : s2_addr;
      wdata    <= clr_req ? '0 : inc;
      w1_vld   <= wen;
      w1_addr  <= waddr;
      w1_data  <= wdata;
      sat_flag <= sat_clr ? 1'b0 : (sat_flag | (vld_pipe[1] & sat_hit));
    end
  end
endmodule

// File: rtl/his_builder_rmw.sv
// Histogram builder: clears RAM, counts (pixel, bin) events through a forwarded
// RMW pipe. Define PEAK_FIND_EN to add a per-pixel peak scan after each frame.
module his_builder_rmw
  import his_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W,
  parameter int PIX_W = DEF_PIX_W,
  parameter int CNT_W = DEF_CNT_W,
  localparam int RAM_AW = ram_aw(PIX_W, BIN_W)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_pixel,
  input  logic [BIN_W-1:0]  in_bin,
  input  logic              in_last,
  output logic [RAM_AW-1:0] raddr,
  output logic              ren,
  input  logic [CNT_W-1:0]  rdata,
  output logic [RAM_AW-1:0] waddr,
  output logic              wen,
  output logic [CNT_W-1:0]  wdata,
  output logic              busy,
  output logic              his_done,
  output logic              sat_flag,
  output logic              peak_valid,
  output logic [PIX_W-1:0]  peak_pixel,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [CNT_W-1:0]  peak_count
);
  his_state_e        state;
  logic [RAM_AW:0]   clr_cnt;
  logic              acc, clr_req, sat_clr, pipe_empty, rd_req;
  logic [RAM_AW-1:0] clr_addr, rd_addr;

  assign acc      = in_valid & in_ready;
  assign sat_clr  = (state == S_IDLE) & start;
  assign clr_req  = sat_clr | ((state == S_CLEAR) & ~clr_cnt[RAM_AW]);
  assign clr_addr = (state == S_IDLE) ? '0 : clr_cnt[RAM_AW-1:0];

`ifdef PEAK_FIND_EN
  logic [RAM_AW:0]   scan_cnt;
  logic [1:0]        sc_vld;
  logic [RAM_AW-1:0] sc_addr0, sc_addr1;
  logic [CNT_W-1:0]  max_cnt, cand_cnt;
  logic [BIN_W-1:0]  max_bin, cand_bin, cur_bin;
  logic              take, scan_fin;

  assign rd_req   = ((state == S_DRAIN) & pipe_empty) | ((state == S_SCAN) & ~scan_cnt[RAM_AW]);
  assign rd_addr  = (state == S_DRAIN) ? '0 : scan_cnt[RAM_AW-1:0];
  assign cur_bin  = sc_addr1[BIN_W-1:0];
  // Bin 0 always seeds the running max; strict > keeps the lowest bin on ties.
  assign take     = (cur_bin == '0) || (rdata > max_cnt);
  assign cand_cnt = take ? rdata : max_cnt;
  assign cand_bin = take ? cur_bin : max_bin;
  assign scan_fin = sc_vld[1] & (&sc_addr1);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      scan_cnt   <= '0;
      sc_vld     <= '0;
      sc_addr0   <= '0;
      sc_addr1   <= '0;
      max_cnt    <= '0;
      max_bin    <= '0;
      peak_valid <= 1'b0;
      peak_pixel <= '0;
      peak_bin   <= '0;
      peak_count <= '0;
    end else begin
      peak_valid <= 1'b0;
      sc_vld     <= {sc_vld[0], rd_req};
      sc_addr0   <= rd_addr;
      sc_addr1   <= sc_addr0;
      if (rd_req) scan_cnt <= {1'b0, rd_addr} + 1'b1;
      if (sc_vld[1]) begin
        max_cnt <= cand_cnt;
        max_bin <= cand_bin;
        if (&cur_bin) begin
          peak_valid <= 1'b1;
          peak_pixel <= sc_addr1[RAM_AW-1:BIN_W];
          peak_bin   <= cand_bin;
          peak_count <= cand_cnt;
        end
      end
    end
  end
`else
  assign rd_req     = 1'b0;
  assign rd_addr    = '0;
  assign peak_valid = 1'b0;
  assign peak_pixel = '0;
  assign peak_bin   = '0;
  assign peak_count = '0;
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= S_IDLE;
      clr_cnt  <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      his_done <= 1'b0;
    end else begin
      his_done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state   <= S_CLEAR;
          clr_cnt <= {{RAM_AW{1'b0}}, 1'b1};
          busy    <= 1'b1;
        end
        S_CLEAR: begin
          if (clr_cnt[RAM_AW]) begin
            state    <= S_BUILD;
            in_ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_BUILD: if (acc && in_last) begin
          state    <= S_DRAIN;
          in_ready <= 1'b0;
        end
        S_DRAIN: if (pipe_empty) begin
`ifdef PEAK_FIND_EN
          state <= S_SCAN;
`else
          state    <= S_DONE;
          his_done <= 1'b1;
`endif
        end
`ifdef PEAK_FIND_EN
        S_SCAN: if (scan_fin) begin
          state    <= S_DONE;
          his_done <= 1'b1;
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  his_rmw_pipe #(.RAM_AW(RAM_AW), .CNT_W(CNT_W)) u_pipe (
    .clk      (clk),
    .res      (res),
    .acc      (acc),
    .acc_addr ({in_pixel, in_bin}),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .clr_req  (clr_req),
    .clr_addr (clr_addr),
    .sat_clr  (sat_clr),
    .rdata    (rdata),
    .ren      (ren),
    .raddr    (raddr),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .sat_flag (sat_flag),
    .empty    (pipe_empty)
  );
endmodule

// File: tb/tb_his_builder_rmw.sv
// Scoreboard bench: RAM model plus per-bin saturating counters predict every write.
module tb_his_builder_rmw;
  localparam int BIN_W = 4, PIX_W = 2, CNT_W = 4;
  localparam int AW = 6, N = 64, MAX = 15;

  logic clk = 0, res = 1, start = 0, in_valid = 0, in_last = 0, preload = 0;
  logic [PIX_W-1:0] in_pixel = '0;
  logic [BIN_W-1:0] in_bin = '0;
  logic in_ready, ren, wen, busy, his_done, sat_flag, peak_valid;
  logic [AW-1:0] raddr, waddr;
  logic [CNT_W-1:0] rdata, wdata, peak_count;
  logic [PIX_W-1:0] peak_pixel;
  logic [BIN_W-1:0] peak_bin;

  his_builder_rmw #(.BIN_W(BIN_W), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_bin(in_bin), .in_last(in_last), .raddr(raddr), .ren(ren),
    .rdata(rdata), .waddr(waddr), .wen(wen), .wdata(wdata), .busy(busy),
    .his_done(his_done), .sat_flag(sat_flag), .peak_valid(peak_valid),
    .peak_pixel(peak_pixel), .peak_bin(peak_bin), .peak_count(peak_count));

  always #5 clk = ~clk;

  logic [CNT_W-1:0] mem [N];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) mem[i] <= '1;
    end else begin
      if (ren) rdata <= mem[raddr];
      if (wen) mem[waddr] <= wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int pix; int bin; int cnt; } pk_t;
  wr_t exp_q[$];
  pk_t pk_q[$];
  int cnt[N];
  bit sat_exp;
  int total = 0, bad = 0;
  int last_wen_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RAM write and every peak report is popped against the model.
  always @(negedge clk) begin : mon
    wr_t e;
    pk_t p;
    if (res) begin
      if (wen) begin
        last_wen_cyc = cyc;
        if (exp_q.size() == 0) chk("unexpected_write", {26'd0, waddr}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("waddr", {26'd0, waddr}, e.addr);
          chk("wdata", {28'd0, wdata}, e.data);
        end
      end
      if (peak_valid) begin
        if (pk_q.size() == 0) chk("unexpected_peak", {30'd0, peak_pixel}, 32'hFFFF_FFFF);
        else begin
          p = pk_q.pop_front();
          chk("peak_pixel", {30'd0, peak_pixel}, p.pix);
          chk("peak_bin", {28'd0, peak_bin}, p.bin);
          chk("peak_count", {28'd0, peak_count}, p.cnt);
        end
      end
    end
  end

  task automatic do_start();
    int n = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      exp_q.push_back('{i, 0});
    end
    sat_exp = 0;
    @(posedge clk); #1;
    start = 1; in_valid = 1;
    in_pixel = PIX_W'($urandom); in_bin = BIN_W'($urandom);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    while (wen && n < N + 8) begin
      chk("ready_in_clear", {31'd0, in_ready}, 0);
      n++;
      @(negedge clk);
    end
    chk("clear_len", n, N);
    chk("ready_after_clear", {31'd0, in_ready}, 1);
    chk("sat_cleared", {31'd0, sat_flag}, 0);
    in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic send(input int p, input int b, input bit last);
    int n = 0;
    int a;
    in_valid = 1; in_pixel = PIX_W'(p); in_bin = BIN_W'(b); in_last = last;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        chk("accept_timeout", n, 0);
        in_valid = 0; in_last = 0;
        return;
      end
      @(negedge clk);
    end
    a = (p << BIN_W) | b;
    if (cnt[a] == MAX) sat_exp = 1;
    else cnt[a]++;
    exp_q.push_back('{a, cnt[a]});
`ifdef PEAK_FIND_EN
    if (last) begin
      for (int px = 0; px < 4; px++) begin
        int bc, bb;
        bc = cnt[px * 16]; bb = 0;
        for (int bi = 1; bi < 16; bi++)
          if (cnt[px * 16 + bi] > bc) begin bc = cnt[px * 16 + bi]; bb = bi; end
        pk_q.push_back('{px, bb, bc});
      end
    end
`endif
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic gap(input int n);
    in_valid = 0;
    in_pixel = PIX_W'($urandom); in_bin = BIN_W'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic finish_frame(input bit chk_timing);
    int n = 0, m = 0;
    @(negedge clk);
    while (his_done !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("his_done_seen", {31'd0, his_done}, 1);
    chk("busy_in_done", {31'd0, busy}, 1);
    if (chk_timing) chk("done_after_last_write", cyc, last_wen_cyc + 1);
    @(negedge clk);
    chk("done_one_pulse", {31'd0, his_done}, 0);
    chk("busy_falls", {31'd0, busy}, 0);
    chk("sat_flag", {31'd0, sat_flag}, {31'd0, sat_exp});
    chk("writes_drained", exp_q.size(), 0);
    for (int i = 0; i < N; i++) if (mem[i] !== CNT_W'(cnt[i])) m++;
    chk("ram_contents", m, 0);
`ifdef PEAK_FIND_EN
    chk("peaks_drained", pk_q.size(), 0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int nd;
    bit tmode;
`ifdef PEAK_FIND_EN
    tmode = 0;
`else
    tmode = 1;
`endif
    #2 res = 0; preload = 1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, in_ready}, 0);
    chk("rst_wen_ren", {30'd0, wen, ren}, 0);
    chk("rst_done_sat", {30'd0, his_done, sat_flag}, 0);
    chk("rst_peak", {31'd0, peak_valid}, 0);
    repeat (2) @(posedge clk);
    #1 res = 1; preload = 0;

    // Events offered while idle must be ignored.
    in_valid = 1; in_pixel = 2'd1; in_bin = 4'd1;
    repeat (4) @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 0);
    chk("idle_busy", {31'd0, busy}, 0);
    @(posedge clk); #1 in_valid = 0;

    // Frame 1: back-to-back same bin, interleaved bins, random pixel-3 tail.
    do_start();
    for (int i = 0; i < 5; i++) send(1, 7, 0);
    send(0, 3, 0); send(0, 4, 0); send(0, 3, 0); send(0, 4, 0); send(0, 3, 0);
    for (int i = 0; i < 12; i++) begin
      gap($urandom_range(0, 1));
      send(3, $urandom_range(0, 3), i == 11);
    end
    finish_frame(tmode);
    chk("bin_1_7", {28'd0, mem[(1 << BIN_W) | 7]}, 5);
    chk("bin_0_3", {28'd0, mem[3]}, 3);
    chk("bin_0_4", {28'd0, mem[4]}, 2);

    // Frame 2: saturation on one bin; flag must stay set until next clear.
    do_start();
    for (int i = 0; i < 20; i++) send(0, 0, i == 19);
    finish_frame(tmode);
    chk("sat_bin_0", {28'd0, mem[0]}, 15);
    repeat (5) @(negedge clk);
    chk("sat_sticky", {31'd0, sat_flag}, 1);
    @(posedge clk); #1;

    // Frame 3: gapped stream, last on the 10th event.
    do_start();
    for (int i = 0; i < 10; i++) begin
      gap($urandom_range(0, 3));
      send($urandom_range(0, 3), $urandom_range(0, 15), i == 9);
    end
    finish_frame(tmode);

    // Frame 4: tie between bins 5 and 9 of pixel 2.
    do_start();
    for (int i = 0; i < 4; i++) begin send(2, 5, 0); send(2, 9, 0); end
    send(2, 1, 0); send(2, 1, 0);
    send(0, 6, 0); send(1, 2, 0); send(3, 15, 1);
    finish_frame(tmode);
`ifndef PEAK_FIND_EN
    chk("peak_tied_low", {28'd0, peak_count}, 0);
`endif

    // Frame 5: random hazard stress on a small address set.
    do_start();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
      send($urandom_range(0, 1), $urandom_range(0, 2), i == 59);
    end
    finish_frame(tmode);

    // Frame 6: reset in the middle of BUILD aborts silently.
    do_start();
    for (int i = 0; i < 4; i++) send(1, i, 0);
    #1 res = 0;
    @(negedge clk);
    chk("abort_busy_ready", {30'd0, busy, in_ready}, 0);
    chk("abort_wen_ren", {30'd0, wen, ren}, 0);
    chk("abort_done_sat", {30'd0, his_done, sat_flag}, 0);
    chk("abort_peak", {31'd0, peak_valid}, 0);
    exp_q.delete();
    pk_q.delete();
    @(posedge clk); #1 res = 1;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (his_done) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/his_builder_rmw.md
Name: his_builder_rmw

Overview:
- Parametrised successor to the single-pixel histogram builder FSM in the dToF SiFH chain.
- Accepts a stream of (pixel, bin) timestamp events and clears a dual-port histogram SRAM before each frame.
- Increments bins through a pipelined read-modify-write path with hazard forwarding and saturation.
- Signals frame completion; sits between the TDC/event encoder and the histogram SRAM.

Parameters:
- BIN_W, 8, bin address width; 2^BIN_W bins per pixel.
- PIX_W, 2, pixel index width; 2^PIX_W pixels share one RAM.
- CNT_W, 8, bin counter width (RAM data width).
- Derived localparam RAM_AW = PIX_W+BIN_W; RAM address = {pixel, bin}.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse starting a frame; honoured in IDLE only.
- in_valid  in  1  event valid.
- in_ready  out  1  event accepted when in_valid&in_ready at a clock edge.
- in_pixel  in  PIX_W  event pixel index.
- in_bin  in  BIN_W  event bin index.
- in_last  in  1  qualifies the final event of the frame.
- raddr  out  RAM_AW  RAM port B address.
- ren  out  1  port B read enable, active-high; RAM read latency 1 cycle.
- rdata  in  CNT_W  port B data.
- waddr  out  RAM_AW  RAM port A address.
- wen  out  1  port A write enable, active-high.
- wdata  out  CNT_W  port A data.
- busy  out  1  high in every state except IDLE.
- his_done  out  1  one-cycle pulse at frame completion.
- sat_flag  out  1  sticky: a bin saturated this frame.
- peak_valid  out  1  one-cycle pulse per pixel peak result.
- peak_pixel  out  PIX_W  pixel of the reported peak.
- peak_bin  out  BIN_W  bin of the reported peak.
- peak_count  out  CNT_W  count of the reported peak.

Behaviour:
- Reset: all outputs 0, state IDLE; pipeline invalidated. RAM contents are undefined after reset; the next start clears them.
- Reset mid-operation aborts the frame with no his_done.
- All outputs are registered.
- States:
  - IDLE: start -> CLEAR; in_ready=0. start outside IDLE is ignored.
  - CLEAR: wen=1, wdata=0, waddr steps 0..2^RAM_AW-1, one address per cycle. After the last address -> BUILD. sat_flag cleared on entry.
  - BUILD: in_ready=1. Per accepted event at edge k:
    - raddr/ren registered at edge k.
    - rdata sampled at edge k+1.
    - waddr/wdata/wen registered at edge k+2 (write latency 3 edges).
    - Accepting the in_last event -> DRAIN.
  - DRAIN: in_ready=0. Holds until the pipeline is empty (last write issued). Then -> SCAN if PEAK_FIND_EN is defined, else -> DONE.
  - DONE: his_done=1 for one cycle -> IDLE.
- Increment: new = (base == 2^CNT_W-1) ? base : base+1. A held (saturated) value sets sat_flag.
- Hazard forwarding: base = rdata, unless the address matches a write computed but not yet visible through rdata (up to 2 in flight). In that case base = the youngest matching computed value. Back-to-back events on one bin must count exactly.
- Throughput: one event per cycle, with no bubbles in BUILD.
- in_valid=0 cycles insert pipeline bubbles (ren=0 in the following cycle).
- Events presented outside BUILD are not accepted and not counted.

Optional Feature:
- Macro PEAK_FIND_EN.
- Defined: SCAN state reads every bin of every pixel in order, one per cycle.
  - Tracks the maximum with strict > comparison, so the lowest bin wins ties.
  - peak_valid pulses one cycle after the last bin data of each pixel, with peak_pixel/peak_bin/peak_count.
  - After the last pixel -> DONE.
  - Scan costs 2^RAM_AW+1 cycles.
- Undefined: SCAN is absent; peak_* outputs are tied to 0.

Decomposition:
- Package his_pkg: state encoding (IDLE, CLEAR, BUILD, DRAIN, SCAN, DONE), default widths, and the RAM_AW/CNT_MAX computation function.
- Sub-module his_rmw_pipe: the 3-stage read-modify-write pipeline with forwarding and saturation. The top level keeps the FSM, clear counter and scan logic.

Test Plan:
- Frame clear: start with RAM preloaded 0xFF -> 2^RAM_AW consecutive wen cycles with wdata=0; in_ready rises the cycle after the last clear write.
- Back-to-back hazard: 5 consecutive events pixel 1 bin 7 -> RAM[{1,7}]=5; writes observed 1,2,3,4,5.
- Interleaved hazard: bins 3,4,3,4,3 of pixel 0 -> RAM[3]=3, RAM[4]=2.
- Saturation (CNT_W=4): 20 events on bin 0 -> RAM[0]=15, sat_flag=1; sat_flag stays 1 until the next start's CLEAR.
- Frame end with gaps: in_valid toggling, in_last on the 10th event -> exactly 10 increments, his_done one pulse after the last write, busy falls with it.
- PEAK_FIND_EN: pixel 2 with bins 5 and 9 both count 4 -> peak_pixel=2, peak_bin=5, peak_count=4. Reset asserted during BUILD -> outputs 0, no his_done.
